jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH SHALL be: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port sync_reset SHALL be: sync_reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port cmd_valid SHALL be: cmd_valid  input  1  command offered.
REQ-005 Port cmd_ready SHALL be: cmd_ready  output  1  FIFO can accept a command.
REQ-006 Port cmd_op SHALL be: cmd_op  input  2  00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 Port cmd_rpt SHALL be: cmd_rpt  input  4  issue count minus one.
REQ-008 Port j SHALL be: j  output  1  registered J drive to the downstream JK flop.
REQ-009 Port k SHALL be: k  output  1  registered K drive to the downstream JK flop.
REQ-010 Port issue SHALL be: issue  output  1  high in every cycle j/k carry a command.
REQ-011 Port q_fb SHALL be: q_fb  input  1  q returned from the downstream flop.
REQ-012 Port shadow_q SHALL be: shadow_q  output  1  predicted downstream q.
REQ-013 Port depth SHALL be: depth  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port mismatch SHALL be: mismatch  output  1  sticky q_fb/shadow_q disagreement flag.

Function
REQ-015 cmd_ready SHALL be depth<DEPTH and sync_reset low; a command SHALL be accepted on each edge with cmd_valid&&cmd_ready.
REQ-016 The FIFO SHALL be first-in first-out; push and pop on the same edge SHALL leave depth unchanged.
REQ-017 The issue engine SHALL have two states: IDLE (j=k=0, issue=0) and ISSUE.
REQ-018 In IDLE with depth>0, the engine SHALL pop the head, load remaining=cmd_rpt and enter ISSUE; the first issue cycle SHALL start the edge after acceptance into an empty FIFO.
REQ-019 In ISSUE, each cycle SHALL drive j=op[1], k=op[0], issue=1, and decrement remaining.
REQ-020 When remaining=0 and depth>0, the engine SHALL pop the next command on that edge with no bubble cycle; with depth=0 it SHALL return to IDLE.
REQ-021 cmd_rpt=15 SHALL yield exactly 16 consecutive issue cycles.
REQ-022 At each edge with issue=1, shadow_q SHALL update per JK rules: 00 hold, 01 set to 0, 10 set to 1, 11 invert.
REQ-023 A full FIFO SHALL hold cmd_ready low until the edge after a pop.

Reset
REQ-024 sync_reset SHALL empty the FIFO (depth=0) and set state IDLE, j=0, k=0, issue=0, shadow_q=0, mismatch=0, and the check-armed bit to 0.
REQ-025 Reset asserted mid-ISSUE SHALL abort the current command and discard all queued commands on that edge.
REQ-026 cmd_valid SHALL be ignored while sync_reset is high.

Configuration
REQ-027 Macro JK_SEQ_CHECK_EN defined SHALL enable checking.
REQ-028 With checking enabled, the check SHALL arm on the first issued clear or set command.
REQ-029 Once armed, any cycle with q_fb!=shadow_q SHALL set mismatch, which SHALL hold until sync_reset.
REQ-030 With JK_SEQ_CHECK_EN undefined, mismatch SHALL be tied to 0, q_fb SHALL be unused, and the compare/arm logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then push op=10 rpt=0 -> one issue cycle with j=1, k=0 the edge after acceptance; shadow_q=1; then IDLE with j=k=0.
REQ-032 Push op=11 rpt=3, then op=01 rpt=0 back-to-back -> 4 toggle cycles followed immediately by 1 clear cycle, no gap; shadow_q ends at 0.
REQ-033 Push 5 commands with DEPTH=4 and the engine stalled behind rpt=15 -> cmd_ready=0 at depth=4; the 5th command is accepted only the edge after a pop.
REQ-034 Assert sync_reset during the 3rd cycle of a rpt=7 command with 2 queued -> next cycle issue=0, depth=0, shadow_q=0, cmd_ready=1 after release.
REQ-035 With JK_SEQ_CHECK_EN, issue set then force q_fb=0 -> mismatch=1 and stays 1 until sync_reset; without the macro -> mismatch=0 throughout.

Source files
------------

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle for jk_cmd_sequencer: producer uses master, sequencer uses slave.
interface jk_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_rpt;

   modport master (output cmd_valid, output cmd_op, output cmd_rpt, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_rpt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: FIFO-buffered JK command issuer that tracks the downstream flop in shadow_q.
// Defining JK_SEQ_CHECK_EN compiles in the sticky q_fb/shadow_q mismatch check.
module jk_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   sync_reset,
   jk_cmd_sequencer_if.slave      cmd,
   output logic                   j,
   output logic                   k,
   output logic                   issue,
   input  logic                   q_fb,
   output logic                   shadow_q,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   mismatch
);
   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]  ZERO_LVL = {(AW+1){1'b0}};
   localparam logic [AW:0]  ONE_LVL  = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
   localparam logic [0:0]   IDLE     = 1'b0;
   localparam logic [0:0]   ISSUE    = 1'b1;

   logic [5:0]    mem_q [DEPTH];
   logic [5:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   depth_q, depth_d;
   logic [0:0]    state_q, state_d;
   logic [3:0]    remaining_q, remaining_d;
   logic          j_q, j_d, k_q, k_d, issue_q, issue_d, shadow_d;
   logic          cmd_ready_s, push_s, pop_s;
   logic [5:0]    head_s;

   // Next-state for the FIFO and the issue engine; a pop loads the head straight into j/k.
   always_comb begin
      cmd_ready_s = (depth_q < FULL_LVL) && !sync_reset;
      push_s      = cmd.cmd_valid && cmd_ready_s;
      head_s      = mem_q[rd_ptr_q];
      pop_s       = 1'b0;
      state_d     = state_q;
      j_d         = j_q;
      k_d         = k_q;
      issue_d     = issue_q;
      remaining_d = remaining_q;
      shadow_d    = shadow_q;
      case (state_q)
         IDLE: begin
            if (depth_q != ZERO_LVL) begin
               pop_s       = 1'b1;
               state_d     = ISSUE;
               j_d         = head_s[5];
               k_d         = head_s[4];
               remaining_d = head_s[3:0];
               issue_d     = 1'b1;
            end else begin
               j_d     = 1'b0;
               k_d     = 1'b0;
               issue_d = 1'b0;
            end
         end
         ISSUE: begin
            case ({j_q, k_q})
               2'b01:   shadow_d = 1'b0;
               2'b10:   shadow_d = 1'b1;
               2'b11:   shadow_d = ~shadow_q;
               default: shadow_d = shadow_q;
            endcase
            if (remaining_q != 4'd0) begin
               remaining_d = remaining_q - 4'd1;
            end else if (depth_q != ZERO_LVL) begin
               // Chain into the next command on the same edge so bursts stay gap-free.
               pop_s       = 1'b1;
               j_d         = head_s[5];
               k_d         = head_s[4];
               remaining_d = head_s[3:0];
               issue_d     = 1'b1;
            end else begin
               state_d = IDLE;
               j_d     = 1'b0;
               k_d     = 1'b0;
               issue_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            j_d     = 1'b0;
            k_d     = 1'b0;
            issue_d = 1'b0;
         end
      endcase

      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_s) begin
         mem_d[wr_ptr_q] = {cmd.cmd_op, cmd.cmd_rpt};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   depth_d = depth_q + ONE_LVL;
         2'b01:   depth_d = depth_q - ONE_LVL;
         default: depth_d = depth_q;
      endcase
   end

   // Register update; sync_reset aborts the command in flight and drops everything queued.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         mem_q       <= '{default: 6'd0};
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         depth_q     <= ZERO_LVL;
         state_q     <= IDLE;
         remaining_q <= 4'd0;
         j_q         <= 1'b0;
         k_q         <= 1'b0;
         issue_q     <= 1'b0;
         shadow_q    <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         depth_q     <= depth_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
         j_q         <= j_d;
         k_q         <= k_d;
         issue_q     <= issue_d;
         shadow_q    <= shadow_d;
      end
   end

   assign cmd.cmd_ready = cmd_ready_s;
   assign j             = j_q;
   assign k             = k_q;
   assign issue         = issue_q;
   assign depth         = depth_q;

`ifdef JK_SEQ_CHECK_EN
   logic armed_q, armed_d, mismatch_q, mismatch_d;

   // Arm on the first issued clear/set (q is known from then on), then latch any disagreement.
   always_comb begin
      armed_d    = armed_q | (issue_q & (j_q ^ k_q));
      mismatch_d = mismatch_q | (armed_q & (q_fb ^ shadow_q));
   end

   // Check flops share the sequencer's synchronous reset.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         armed_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         armed_q    <= armed_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;
`else
   logic unused_q_fb;
   assign unused_q_fb = q_fb;
   assign mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: stimulus queues expected issue cycles, a monitor checks them.
module tb_jk_cmd_sequencer;
   logic       clk = 1'b0;
   logic       sync_reset;
   logic       j, k, issue, q_fb, shadow_q, mismatch;
   logic [2:0] depth;

   jk_cmd_sequencer_if cif ();

   jk_cmd_sequencer #(.DEPTH(4)) dut (
      .clk(clk), .sync_reset(sync_reset), .cmd(cif), .j(j), .k(k), .issue(issue),
      .q_fb(q_fb), .shadow_q(shadow_q), .depth(depth), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic j;
      logic k;
      logic sh;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   force_q0 = 1'b0;
   logic q_down = 1'b0;
   int   prev_end = 0;
   logic sh_model = 1'b0;
   logic exp_mm;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream JK flop driven by the DUT, fed back as q_fb.
   always @(posedge clk) begin
      if (sync_reset) q_down <= 1'b0;
      else if (issue) begin
         case ({j, k})
            2'b01:   q_down <= 1'b0;
            2'b10:   q_down <= 1'b1;
            2'b11:   q_down <= ~q_down;
            default: q_down <= q_down;
         endcase
      end
   end
   assign q_fb = force_q0 ? 1'b0 : q_down;

   function automatic logic jk_next(input logic sh, input logic [1:0] op);
      case (op)
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         2'b11:   return ~sh;
         default: return sh;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Monitor: every issue cycle must match the head of the scoreboard, idle cycles drive j=k=0.
   always @(negedge clk) begin
      if (mon_en) begin
         if (issue === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_issue: cyc=%0d j=%b k=%b", cyc, j, k);
            end else begin
               mon_e = sb.pop_front();
               if (cyc != mon_e.cyc || j !== mon_e.j || k !== mon_e.k || shadow_q !== mon_e.sh) begin
                  bad++;
                  $display("FAIL issue_cycle: got cyc=%0d j=%b k=%b sh=%b want cyc=%0d j=%b k=%b sh=%b",
                           cyc, j, k, shadow_q, mon_e.cyc, mon_e.j, mon_e.k, mon_e.sh);
               end
            end
         end else begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               total++;
               bad++;
               $display("FAIL missing_issue: cyc=%0d want issue at cyc=%0d", cyc, sb[0].cyc);
               void'(sb.pop_front());
            end
            check("idle_jk", {30'd0, j, k}, 32'd0);
         end
      end
   end

   task automatic push_cmd(input logic [1:0] op, input logic [3:0] rpt, input int n_exp, output int acc);
      int   guard;
      int   start;
      exp_t e;
      @(negedge clk);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_rpt   = rpt;
      #1;
      guard = 0;
      while (cif.cmd_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) begin
         total++;
         bad++;
         $display("FAIL push_timeout: cmd_ready=%b want 1", cif.cmd_ready);
         cif.cmd_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      cif.cmd_valid = 1'b0;
      acc   = cyc;
      start = (acc + 1 > prev_end + 1) ? acc + 1 : prev_end + 1;
      for (int i = 0; i <= int'(rpt); i++) begin
         if (i < n_exp) begin
            e.cyc = start + i;
            e.j   = op[1];
            e.k   = op[0];
            e.sh  = sh_model;
            sb.push_back(e);
         end
         sh_model = jk_next(sh_model, op);
      end
      prev_end = start + int'(rpt);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      int a, x, a_f, g;
      sync_reset    = 1'b1;
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = 2'b00;
      cif.cmd_rpt   = 4'd0;
`ifdef JK_SEQ_CHECK_EN
      exp_mm = 1'b1;
`else
      exp_mm = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      check("rst_issue", issue, 1'b0);
      check("rst_jk", {j, k}, 2'b00);
      check("rst_depth", depth, 3'd0);
      check("rst_shadow", shadow_q, 1'b0);
      check("rst_mismatch", mismatch, 1'b0);
      check("rst_ready", cif.cmd_ready, 1'b0);
      sync_reset = 1'b0;
      #1;
      check("ready_after_rst", cif.cmd_ready, 1'b1);
      mon_en = 1'b1;

      // Single set command.
      push_cmd(2'b10, 4'd0, 1, a);
      wait_drain();
      check("t1_shadow", shadow_q, 1'b1);
      check("t1_depth", depth, 3'd0);

      // Toggle x4 chained into a clear with no bubble.
      push_cmd(2'b11, 4'd3, 4, a);
      push_cmd(2'b01, 4'd0, 1, x);
      wait_drain();
      check("t2_shadow", shadow_q, 1'b0);

      // Stall behind a 16-cycle toggle and overfill the FIFO.
      push_cmd(2'b11, 4'd15, 16, a);
      push_cmd(2'b01, 4'd0, 1, x);
      push_cmd(2'b10, 4'd0, 1, x);
      push_cmd(2'b00, 4'd0, 1, x);
      push_cmd(2'b11, 4'd0, 1, x);
      check("t3_full_depth", depth, 3'd4);
      check("t3_full_ready", cif.cmd_ready, 1'b0);
      push_cmd(2'b10, 4'd0, 1, a_f);
      check("t3_fifth_accept_cyc", a_f, a + 18);
      wait_drain();
      check("t3_shadow", shadow_q, 1'b1);

      // Reset in the 3rd cycle of an 8-cycle set, with two commands queued.
      push_cmd(2'b10, 4'd7, 3, a);
      push_cmd(2'b01, 4'd0, 0, x);
      push_cmd(2'b11, 4'd0, 0, x);
      check("t4_queued", depth, 3'd2);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (cyc != a + 3 && g < 100);
      check("t4_reach_cycle", cyc, a + 3);
      sync_reset    = 1'b1;
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = 2'b10;
      cif.cmd_rpt   = 4'd0;
      @(negedge clk);
      #1;
      check("t4_issue", issue, 1'b0);
      check("t4_depth", depth, 3'd0);
      check("t4_shadow", shadow_q, 1'b0);
      check("t4_ready_in_rst", cif.cmd_ready, 1'b0);
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      sync_reset    = 1'b0;
      #1;
      check("t4_ready_after", cif.cmd_ready, 1'b1);
      check("t4_depth_after", depth, 3'd0);
      check("t4_mismatch", mismatch, 1'b0);
      prev_end = 0;
      sh_model = 1'b0;

      // Mismatch check: set, then pull q_fb low.
      push_cmd(2'b10, 4'd0, 1, a);
      wait_drain();
      check("t5_mm_clean", mismatch, 1'b0);
      force_q0 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("t5_mm_set", mismatch, exp_mm);
      force_q0 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("t5_mm_sticky", mismatch, exp_mm);
      sync_reset = 1'b1;
      @(negedge clk);
      #1;
      check("t5_mm_rst", mismatch, 1'b0);
      sync_reset = 1'b0;
      repeat (2) @(negedge clk);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
